// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I multicycle control path: opcodes,
// instruction classes driven on alu_op, FSM states and mux selects.
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Instruction class handed to alu_decoder.
    typedef enum logic [2:0] {
        CLS_ALU    = 3'b000,
        CLS_LOAD   = 3'b001,
        CLS_STORE  = 3'b010,
        CLS_BRANCH = 3'b011,
        CLS_AUIPC  = 3'b100,
        CLS_LUI    = 3'b101,
        CLS_JALR   = 3'b110,
        CLS_JAL    = 3'b111
    } alu_class_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SRC_IMM   = 2'b01;
    localparam logic [1:0] PC_SRC_ALU   = 2'b10;

    localparam logic [1:0] RES_SRC_ALU  = 2'b00;
    localparam logic [1:0] RES_SRC_MEM  = 2'b01;
    localparam logic [1:0] RES_SRC_PC4  = 2'b10;

    localparam logic [1:0] SRC_A_RS1    = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_ZERO   = 2'b10;

    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    // funct3 010/011 have no branch meaning in RV32I.
    function automatic logic branch_funct3_ok(input logic [2:0] funct3);
        return (funct3 != 3'b010) && (funct3 != 3'b011);
    endfunction

    // Branch condition from the ALU comparison flags.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_op_classifier.sv
// Combinational opcode classifier: maps the 7-bit opcode to an instruction
// class and flags anything outside the supported RV32I subset.
module op_classifier
    import rv32_pkg::*;
#(
    parameter int OP_WIDTH = 7
) (
    input  logic [OP_WIDTH-1:0] opcode,
    output alu_class_e          op_class,
    output logic                legal
);

    // Opcode lookup; FENCE, SYSTEM and unknown opcodes are illegal.
    always_comb begin
        op_class = CLS_ALU;
        legal    = 1'b1;
        case (opcode)
            OP_WIDTH'(OPC_OP), OP_WIDTH'(OPC_OP_IMM): op_class = CLS_ALU;
            OP_WIDTH'(OPC_LOAD):                     op_class = CLS_LOAD;
            OP_WIDTH'(OPC_STORE):                    op_class = CLS_STORE;
            OP_WIDTH'(OPC_BRANCH):                   op_class = CLS_BRANCH;
            OP_WIDTH'(OPC_AUIPC):                    op_class = CLS_AUIPC;
            OP_WIDTH'(OPC_LUI):                      op_class = CLS_LUI;
            OP_WIDTH'(OPC_JALR):                     op_class = CLS_JALR;
            OP_WIDTH'(OPC_JAL):                      op_class = CLS_JAL;
            default:                                 legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, sharing one ALU and one memory port.
// Outputs are decoded from the state and IR (Mealy on mem_ready/flags).
module multicycle_ctrl
    import rv32_pkg::*;
#(
    parameter int ALUOP_WIDTH = 3,
    parameter int OP_WIDTH    = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            instr,
    input  logic                   alu_zero,
    input  logic                   alu_lt,
    input  logic                   alu_ltu,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   addr_sel,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic [1:0]             pc_src,
    output logic                   reg_we,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic                   alu_src_b,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   retire,
    output logic                   illegal
);

    state_e              state_reg;
    logic                illegal_reg;
    alu_class_e          op_class;
    alu_class_e          cls_out;
    logic                op_legal;
    logic [OP_WIDTH-1:0] opcode;
    logic [2:0]          funct3;
    logic                is_r_type;
    logic                br_ok;
    logic                br_taken;
    logic                unused_instr_bits;

    assign opcode            = instr[OP_WIDTH-1:0];
    assign funct3            = instr[14:12];
    assign is_r_type         = (opcode == OP_WIDTH'(OPC_OP));
    assign br_ok             = branch_funct3_ok(funct3);
    assign br_taken          = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    op_classifier #(
        .OP_WIDTH (OP_WIDTH)
    ) u_classifier (
        .opcode   (opcode),
        .op_class (op_class),
        .legal    (op_legal)
    );

    // State sequencing and the sticky illegal flag (set on entry to HALT).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (mem_ready) state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (op_legal) begin
                        state_reg <= ST_EXECUTE;
                    end else begin
                        state_reg   <= ST_HALT;
                        illegal_reg <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    if (op_class == CLS_BRANCH) begin
                        if (br_ok) begin
                            state_reg <= ST_FETCH;
                        end else begin
                            state_reg   <= ST_HALT;
                            illegal_reg <= 1'b1;
                        end
                    end else if (op_class == CLS_LOAD || op_class == CLS_STORE) begin
                        state_reg <= ST_MEMORY;
                    end else begin
                        state_reg <= ST_WRITEBACK;
                    end
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        state_reg <= (op_class == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: state_reg <= ST_FETCH;
                ST_HALT:      state_reg <= ST_HALT;
                default:      state_reg <= ST_FETCH;
            endcase
        end
    end

    // Control decode; everything is forced low while rst is high so an
    // outstanding memory request is dropped in the reset cycle itself.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_PLUS4;
        reg_we     = 1'b0;
        result_src = RES_SRC_ALU;
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        cls_out    = CLS_ALU;
        retire     = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                ST_DECODE: begin
                    cls_out = op_class;
                end
                ST_EXECUTE: begin
                    cls_out = op_class;
                    case (op_class)
                        CLS_ALU:   alu_src_b = is_r_type ? SRC_B_RS2 : SRC_B_IMM;
                        CLS_LOAD, CLS_STORE, CLS_JALR: alu_src_b = SRC_B_IMM;
                        CLS_AUIPC: begin
                            alu_src_a = SRC_A_PC;
                            alu_src_b = SRC_B_IMM;
                        end
                        CLS_LUI: begin
                            alu_src_a = SRC_A_ZERO;
                            alu_src_b = SRC_B_IMM;
                        end
                        default: ;
                    endcase
                    if (op_class == CLS_BRANCH && br_ok) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        pc_src = br_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                    end
                end
                ST_MEMORY: begin
                    cls_out  = op_class;
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (op_class == CLS_STORE);
                    if (op_class == CLS_STORE && mem_ready) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    cls_out = op_class;
                    reg_we  = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    if (op_class == CLS_LOAD) begin
                        result_src = RES_SRC_MEM;
                    end else if (op_class == CLS_JAL || op_class == CLS_JALR) begin
                        result_src = RES_SRC_PC4;
                    end
                    if (op_class == CLS_JAL) begin
                        pc_src = PC_SRC_IMM;
                    end else if (op_class == CLS_JALR) begin
                        pc_src = PC_SRC_ALU;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_op  = ALUOP_WIDTH'(cls_out);
    assign illegal = illegal_reg & ~rst;

endmodule
